// File: rtl/rggen_rtl_pkg.sv
// rtl/rggen_rtl_pkg.sv - shared bus direction and response status types
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'd0,
        RGGEN_EXOKAY       = 2'd1,
        RGGEN_SLAVE_ERROR  = 2'd2,
        RGGEN_DECODE_ERROR = 2'd3
    } rggen_status;

endpackage

// File: rtl/rggen_bus_slave_ram_if.sv
// rtl/rggen_bus_slave_ram_if.sv - request/done register bus between master and slave
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
);
    import rggen_rtl_pkg::*;

    logic                      request;
    logic [ADDRESS_WIDTH-1:0]  address;
    rggen_direction            direction;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   write_strobe;
    logic                      done;
    logic [DATA_WIDTH-1:0]     read_data;
    rggen_status               status;

    modport master (
        output request, address, direction, write_data, write_strobe,
        input  done, read_data, status
    );

    modport slave (
        input  request, address, direction, write_data, write_strobe,
        output done, read_data, status
    );

endinterface

// File: rtl/rggen_bus_slave_ram.sv
// rtl/rggen_bus_slave_ram.sv - RAM bus slave with fixed wait states
// Optional write_protect port enabled by RGGEN_BUS_SLAVE_RAM_WRITE_PROTECT_EN.
module rggen_bus_slave_ram
    import rggen_rtl_pkg::*;
#(
    parameter int                    ADDRESS_WIDTH = 8,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    WORDS         = 16,
    parameter int                    WAIT_CYCLES   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input logic        clk,
    input logic        rst_n,
`ifdef RGGEN_BUS_SLAVE_RAM_WRITE_PROTECT_EN
    input logic        write_protect,
`endif
    rggen_bus_if.slave bus_if
);

    localparam int         STRB_W     = DATA_WIDTH / 8;
    localparam int         BYTE_BITS  = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int         IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    state_e                    r_state;
    logic [3:0]                r_count;
    logic [ADDRESS_WIDTH-1:0]  r_address;
    rggen_direction            r_direction;
    logic [DATA_WIDTH-1:0]     r_write_data;
    logic [STRB_W-1:0]         r_write_strobe;
    logic                      r_done;
    logic [DATA_WIDTH-1:0]     r_read_data;
    rggen_status               r_status;
    logic [DATA_WIDTH-1:0]     r_mem [WORDS];

    logic                      w_idle;
    logic                      w_accept;
    logic                      w_enter_done;
    logic [ADDRESS_WIDTH-1:0]  w_address;
    rggen_direction            w_direction;
    logic [DATA_WIDTH-1:0]     w_write_data;
    logic [STRB_W-1:0]         w_write_strobe;
    logic                      w_protect;
    logic [31:0]               w_index;
    logic                      w_in_range;
    logic [IDX_W-1:0]          w_word;
    logic                      w_write_en;
    rggen_status               w_status;
    logic [DATA_WIDTH-1:0]     w_read_data;

    // With zero wait cycles the access completes straight from IDLE, so the
    // live bus fields are used instead of the not-yet-captured copies.
    assign w_idle         = (r_state == IDLE);
    assign w_accept       = w_idle && bus_if.request;
    assign w_enter_done   = (w_accept && (WAIT_CYCLES == 0))
                         || ((r_state == WAIT) && (r_count == LAST_COUNT));
    assign w_address      = w_idle ? bus_if.address      : r_address;
    assign w_direction    = w_idle ? bus_if.direction    : r_direction;
    assign w_write_data   = w_idle ? bus_if.write_data   : r_write_data;
    assign w_write_strobe = w_idle ? bus_if.write_strobe : r_write_strobe;

`ifdef RGGEN_BUS_SLAVE_RAM_WRITE_PROTECT_EN
    logic r_protect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_protect <= 1'b0;
        end else if (w_accept) begin
            r_protect <= write_protect;
        end
    end

    assign w_protect = w_idle ? write_protect : r_protect;
`else
    assign w_protect = 1'b0;
`endif

    assign w_index     = 32'(w_address) >> BYTE_BITS;
    assign w_in_range  = (w_index < 32'(WORDS));
    assign w_word      = w_index[IDX_W-1:0];
    assign w_write_en  = w_enter_done && w_in_range
                      && (w_direction == RGGEN_WRITE) && !w_protect;
    assign w_read_data = (w_in_range && (w_direction == RGGEN_READ)) ? r_mem[w_word] : '0;

    always_comb begin
        w_status = RGGEN_OKAY;
        if (!w_in_range) begin
            w_status = RGGEN_DECODE_ERROR;
        end else if ((w_direction == RGGEN_WRITE) && w_protect) begin
            w_status = RGGEN_SLAVE_ERROR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_count        <= 4'd0;
            r_address      <= '0;
            r_direction    <= RGGEN_READ;
            r_write_data   <= '0;
            r_write_strobe <= '0;
            r_done         <= 1'b0;
            r_read_data    <= '0;
            r_status       <= RGGEN_OKAY;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus_if.request) begin
                        r_address      <= bus_if.address;
                        r_direction    <= bus_if.direction;
                        r_write_data   <= bus_if.write_data;
                        r_write_strobe <= bus_if.write_strobe;
                        r_count        <= 4'd0;
                        r_state        <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (r_count == LAST_COUNT) begin
                        r_state <= DONE;
                    end else begin
                        r_count <= r_count + 4'd1;
                    end
                end
                default: begin
                    r_count <= 4'd0;
                    r_state <= IDLE;
                end
            endcase

            // Response registers are loaded only on the edge into DONE and
            // fall back to zero/OKAY on every other edge.
            if (w_enter_done) begin
                r_done      <= 1'b1;
                r_read_data <= w_read_data;
                r_status    <= w_status;
            end else begin
                r_done      <= 1'b0;
                r_read_data <= '0;
                r_status    <= RGGEN_OKAY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WORDS; w++) begin
                r_mem[w] <= INIT_VALUE;
            end
        end else if (w_write_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_write_strobe[b]) begin
                    r_mem[w_word][8*b +: 8] <= w_write_data[8*b +: 8];
                end
            end
        end
    end

    assign bus_if.done      = r_done;
    assign bus_if.read_data = r_read_data;
    assign bus_if.status    = r_status;

endmodule

// File: doc/rggen_bus_slave_ram.md
RGGEN_BUS_SLAVE_RAM -- requirements
Module: rggen_bus_slave_ram

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8: byte-address width of bus_if.address.
REQ-002 Parameter DATA_WIDTH, default 32: data width; SHALL be a multiple of 8.
REQ-003 Parameter WORDS, default 16: number of DATA_WIDTH-bit storage words.
REQ-004 Parameter WAIT_CYCLES, default 0: extra wait cycles inserted before done, range 0..15.
REQ-005 Parameter INIT_VALUE, default '0: reset value of every storage word.
REQ-006 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 bus_if  rggen_bus_if.slave  -  consumes request, address, direction, write_data and write_strobe; drives done, read_data and status.

Function
REQ-009 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-010 In IDLE, request=1 SHALL capture address, direction, write_data and write_strobe, then move to WAIT if WAIT_CYCLES>0, otherwise to DONE.
REQ-011 WAIT SHALL count WAIT_CYCLES cycles with a 4-bit counter, then move to DONE.
REQ-012 done SHALL be 1 for exactly one cycle, in DONE, which is WAIT_CYCLES+1 cycles after the cycle request is first sampled high in IDLE.
REQ-013 DONE SHALL always return to IDLE, and request SHALL be ignored in the DONE cycle, so requests are accepted at most once every WAIT_CYCLES+2 cycles.
REQ-014 Word index = captured address >> log2(DATA_WIDTH/8); the low byte-offset bits SHALL be ignored.
REQ-015 An index >= WORDS SHALL give status RGGEN_DECODE_ERROR and read_data 0, and a write to it SHALL leave storage unchanged.
REQ-016 An in-range write SHALL update byte i of the word only where write_strobe[i]=1, on the edge entering DONE, with status RGGEN_OKAY.
REQ-017 An in-range read SHALL return the word contents as they were before that edge, in the DONE cycle, with status RGGEN_OKAY.
REQ-018 read_data SHALL be 0 and status RGGEN_OKAY whenever done=0.
REQ-019 Input changes while in WAIT or DONE SHALL NOT affect the access in progress.

Reset
REQ-020 When rst_n=0: state=IDLE, counter=0, done=0, read_data=0, status=RGGEN_OKAY, every word=INIT_VALUE.
REQ-021 Reset asserted mid-access SHALL abandon the access: no done pulse and no storage update.

Configuration
REQ-022 Macro RGGEN_BUS_SLAVE_RAM_WRITE_PROTECT_EN, when defined, SHALL add port write_protect (input, 1 bit).
REQ-023 With the macro defined, an in-range write whose request is captured while write_protect=1 SHALL leave storage unchanged and return RGGEN_SLAVE_ERROR.
REQ-024 Without the macro, the port SHALL be absent and every in-range write SHALL be performed.

Structure
REQ-025 rggen_direction (RGGEN_READ/RGGEN_WRITE) and rggen_status (RGGEN_OKAY, RGGEN_EXOKAY, RGGEN_SLAVE_ERROR, RGGEN_DECODE_ERROR) SHALL come from rggen_rtl_pkg.
REQ-026 The FSM state enum SHALL be local to the module.
REQ-027 The block SHALL have no sub-module: storage, counter and FSM SHALL be inline.

Verification (DATA_WIDTH=32, WORDS=16, WAIT_CYCLES=2, INIT_VALUE=0)
REQ-028 After reset, read address 0x08: done rises 3 cycles after request, read_data=0x00000000, status=RGGEN_OKAY.
REQ-029 Write 0x04, data 0xA5A51234, strobe 0b0101, then read 0x04: read_data=0x00A50034, RGGEN_OKAY.
REQ-030 Write 0x40 (index 16), then read 0x40: both return RGGEN_DECODE_ERROR with read_data=0, and all 16 words remain 0.
REQ-031 Hold request high continuously: done pulses are one cycle wide and exactly 4 cycles apart.
REQ-032 Write 0x0C with 0xFFFFFFFF, strobe 0xF; assert rst_n=0 in the WAIT state: no done pulse; a later read of 0x0C returns 0.
REQ-033 With the macro defined, write_protect=1, write 0x00 with 0x12345678: RGGEN_SLAVE_ERROR; a later read of 0x00 returns 0 with RGGEN_OKAY.
